// File: rtl/regbank_hs.sv
// Parametrised register bank behind a valid/ready request/response handshake.
// Each register is RW, RO (hardware-driven) or W1C (sticky status with hardware set).
module regbank_hs #(
  parameter int                         DATA_W    = 32,
  parameter int                         NUM_REGS  = 8,
  parameter int                         ADDR_W    = 8,
  parameter logic [2*NUM_REGS-1:0]      MODE      = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_ro_val,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {
    MODE_RW  = 2'd0,
    MODE_RO  = 2'd1,
    MODE_W1C = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  logic                             accept;
  logic                             in_range;
  logic [NUM_REGS-1:0]              sel;
  logic [NUM_REGS-1:0]              pulse_d;
  logic [DATA_W-1:0]                wmask;
  logic [DATA_W-1:0]                rd_val;
  logic [NUM_REGS-1:0][DATA_W-1:0]  rd_src;
  logic [NUM_REGS-1:0][DATA_W-1:0]  q_out;

  // One response slot: a new request fits when the slot is empty or draining now.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  // Extra bit keeps the compare correct when NUM_REGS == 2**ADDR_W.
  assign in_range  = ({1'b0, req_addr} < (ADDR_W+1)'(NUM_REGS));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wmask = '0;
    for (int b = 0; b < NB; b++) begin
      wmask[8*b +: 8] = {8{req_wstrb[b]}};
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = in_range && (req_addr == ADDR_W'(i));
      if (sel[i]) rd_val = rd_src[i];
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam mode_e M = mode_e'(MODE[2*i +: 2]);
    logic wr_hit;
    assign wr_hit = accept && req_write && sel[i];

    if (M == MODE_RW) begin : g_rw
      logic [DATA_W-1:0] q;
      // NOTE: register contents are reset to RESET_VAL because software relies on defined power-up values.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       q <= RESET_VAL[i*DATA_W +: DATA_W];
        else if (wr_hit) q <= (q & ~wmask) | (req_wdata & wmask);
      end
      assign rd_src[i]  = q;
      assign q_out[i]   = q;
      assign pulse_d[i] = wr_hit;
    end else if (M == MODE_W1C) begin : g_w1c
      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] clr;
      assign clr = wr_hit ? (req_wdata & wmask) : '0;
      // Set is applied after clear so a simultaneous hardware event is never lost.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q <= RESET_VAL[i*DATA_W +: DATA_W];
        else       q <= (q & ~clr) | hw_set[i*DATA_W +: DATA_W];
      end
      assign rd_src[i]  = q;
      assign q_out[i]   = q;
      assign pulse_d[i] = wr_hit;
    end else begin : g_ro
      assign rd_src[i]  = hw_ro_val[i*DATA_W +: DATA_W];
      assign q_out[i]   = '0;
      assign pulse_d[i] = 1'b0;
    end
  end

  assign regs_out = q_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_pulse  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      wr_pulse <= pulse_d;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= req_write ? '0 : rd_val;
        rsp_err   <= !in_range;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
